pcie_drain: RTL and testbench
=============================

PCIE_DRAIN -- requirements
Module: pcie_drain

Interface
REQ-001 Parameter BITNUMBER, default 6, width of each data word.
REQ-002 Parameter CNT_WIDTH, default 8, width of each per-destination word counter.
REQ-003 The port list SHALL be exactly the following, in this order:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  permits new pops when high.
- can_pop0, can_pop1  input  1 each  destination FIFO D0/D1 has data.
- valid_in0, valid_in1  input  1 each  FIFO read-valid; data present this cycle.
- data_in0, data_in1  input  BITNUMBER each  FIFO read data.
- out_ready  input  1  sink accepts the output word.
- pop_D0, pop_D1  output  1 each  pop strobe to D0/D1.
- data_out  output  BITNUMBER  head word of the output buffer.
- dest_out  output  1  source of data_out (0=D0, 1=D1).
- valid_out  output  1  data_out/dest_out valid.
- req  input  1  count-read request strobe.
- req_idx  input  1  counter selected (0=D0, 1=D1).
- clr  input  1  synchronous clear of both counters.
- count_out  output  CNT_WIDTH  requested count.
- count_valid  output  1  count_out valid.
- idle  output  1  FSM in IDLE.
- proto_err  output  1  sticky protocol error.

Function
REQ-004 The block SHALL hold a 2-entry output FIFO of {dest, data}; occ = entries held (0..2).
REQ-005 inflight SHALL be 1 in the cycle after a pop strobe, else 0; at most one pop strobe per cycle.
REQ-006 A pop SHALL be issued only if state=RUN and credit = occ + inflight - (valid_out && out_ready) <= 1.
REQ-007 Arbitration: only can_pop0 -> pop_D0; only can_pop1 -> pop_D1; both -> the FIFO not granted last; last-grant SHALL reset to D1, so D0 wins first.
REQ-008 Fetch latency: pop in cycle N -> valid_inX expected in N+1; the word SHALL be written into the output FIFO at the end of N+1 and appear on data_out no earlier than N+2.
REQ-009 valid_inX asserted with no matching pop in the prior cycle SHALL be discarded and set proto_err=1 until reset.
REQ-010 Transfer occurs when valid_out && out_ready; simultaneous write and transfer SHALL leave occ unchanged; data_out/dest_out SHALL hold stable while valid_out && !out_ready.
REQ-011 Word order on data_out SHALL equal pop order.
REQ-012 FSM states:
- IDLE: enable=1 -> RUN.
- RUN: enable=0 and (occ>0 or inflight) -> DRAIN; enable=0 and empty -> IDLE.
- DRAIN: occ=0 and !inflight -> IDLE; enable=1 -> RUN.
- No pops in IDLE or DRAIN; in-flight data SHALL still be captured and delivered.
REQ-013 cnt0/cnt1 SHALL increment on each transfer with dest 0/1 and saturate at 2^CNT_WIDTH-1.
REQ-014 clr SHALL zero both counters next edge, with priority over a same-cycle increment.
REQ-015 req in cycle N SHALL drive count_out = counter[req_idx] value at start of N and count_valid=1 in cycle N+1 only (pre-clear value if clr same cycle).
REQ-016 Back-to-back req SHALL each produce one response; count_out SHALL hold its last value when count_valid=0.

Reset
REQ-017 reset low SHALL immediately force: state=IDLE, idle=1, occ=0, inflight=0, last-grant=D1, cnt0=cnt1=0, proto_err=0, pop_D0=pop_D1=0, valid_out=0, data_out=0, dest_out=0, count_out=0, count_valid=0.
REQ-018 A word in flight when reset asserts SHALL be lost; after reset deasserts, the first valid_inX without a prior pop SHALL set proto_err.

Verification
REQ-019 enable=1, can_pop0=1 only, out_ready=1, D0 returns 0x2A -> pop_D0 in N, data_out=0x2A dest_out=0 valid_out=1 at N+2.
REQ-020 Both can_pop high, out_ready=1 for 6 cycles -> pops alternate D0,D1,D0,...; one word per cycle on data_out after fill.
REQ-021 out_ready=0 with both sources ready -> exactly 2 pops, then pop strobes 0, data_out stable; out_ready=1 -> output resumes with no loss or reorder.
REQ-022 Transfer 3 words from D1, then req=1 req_idx=1 -> next cycle count_out=3 count_valid=1; clr+req together -> count_out=3, next req reads 0.
REQ-023 enable drops the cycle after a pop -> state DRAIN, that word still delivered, then idle=1; valid_in0 pulse with no pop -> proto_err=1.
REQ-024 reset low mid-transfer with occ=2 -> all outputs at REQ-017 values immediately; cnt0 saturates at 255 after 300 D0 transfers.

Source files
------------

// File: rtl/pcie_drain.sv
// Pops words from two destination FIFOs with round-robin arbitration and
// credit-based flow control, buffers them in a 2-entry output FIFO, and keeps per-source transfer counters.
module pcie_drain #(
  parameter int unsigned BITNUMBER = 6,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 can_pop0,
  input  logic                 can_pop1,
  input  logic                 valid_in0,
  input  logic                 valid_in1,
  input  logic [BITNUMBER-1:0] data_in0,
  input  logic [BITNUMBER-1:0] data_in1,
  input  logic                 out_ready,
  output logic                 pop_D0,
  output logic                 pop_D1,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 dest_out,
  output logic                 valid_out,
  input  logic                 req,
  input  logic                 req_idx,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 count_valid,
  output logic                 idle,
  output logic                 proto_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BITNUMBER-1:0] data_q [2];
  logic                 dst_q  [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, infl_dest_q, last_grant_q;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q, count_out_q;
  logic                 count_valid_q, proto_err_q;

  logic                 xfer, wr_en, stray, credit_ok, grant1, pop_any;
  logic [BITNUMBER-1:0] wr_data;
  logic [2:0]           credit;

  // Datapath decode: transfer, capture of the returning word, credit and arbitration.
  always_comb begin
    xfer      = (occ_q != 2'd0) && out_ready;
    wr_en     = inflight_q && (infl_dest_q ? valid_in1 : valid_in0);
    wr_data   = infl_dest_q ? data_in1 : data_in0;
    stray     = (valid_in0 && !(inflight_q && !infl_dest_q)) ||
                (valid_in1 && !(inflight_q && infl_dest_q));
    credit    = 3'(occ_q) + 3'(inflight_q) - 3'(xfer);
    credit_ok = credit <= 3'd1;
    grant1    = (can_pop0 && can_pop1) ? !last_grant_q : can_pop1;
    occ_d     = occ_q + 2'(wr_en) - 2'(xfer);
  end

  // Next-state and pop strobes; pops only while running and enabled.
  always_comb begin
    state_d = state_q;
    pop_any = 1'b0;
    pop_D0  = 1'b0;
    pop_D1  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        pop_any = enable && credit_ok && (can_pop0 || can_pop1);
        pop_D1  = pop_any && grant1;
        pop_D0  = pop_any && !grant1;
        if (!enable) state_d = ((occ_q != 2'd0) || inflight_q) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if ((occ_q == 2'd0) && !inflight_q) state_d = S_IDLE;
        else if (enable)                    state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      inflight_q   <= 1'b0;
      infl_dest_q  <= 1'b0;
      last_grant_q <= 1'b1;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= pop_any;
      infl_dest_q  <= pop_D1;
      if (pop_any) last_grant_q <= pop_D1;
      if (stray)   proto_err_q  <= 1'b1;
    end
  end

  // Output FIFO storage; entries are reset so data_out reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      dst_q[0]  <= 1'b0;
      dst_q[1]  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (wr_en) begin
        data_q[wr_ptr_q] <= wr_data;
        dst_q[wr_ptr_q]  <= infl_dest_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (xfer) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

  // Saturating per-source counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
    end else begin
      if (clr) begin
        cnt0_q <= '0;
        cnt1_q <= '0;
      end else if (xfer) begin
        if (!dst_q[rd_ptr_q] && (cnt0_q != CNT_MAX)) cnt0_q <= cnt0_q + CNT_WIDTH'(1);
        if (dst_q[rd_ptr_q] && (cnt1_q != CNT_MAX))  cnt1_q <= cnt1_q + CNT_WIDTH'(1);
      end
      if (req) count_out_q <= req_idx ? cnt1_q : cnt0_q;
      count_valid_q <= req;
    end
  end

  assign data_out    = data_q[rd_ptr_q];
  assign dest_out    = dst_q[rd_ptr_q];
  assign valid_out   = occ_q != 2'd0;
  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign idle        = state_q == S_IDLE;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_pcie_drain.sv
// Scoreboard bench for pcie_drain: a responder answers pops and queues expected words,
// a monitor checks output order and a counter model; directed scenarios then random traffic.
module tb_pcie_drain;

  localparam int unsigned BW = 6;
  localparam int unsigned CW = 8;

  logic          clk, reset, enable, can_pop0, can_pop1, valid_in0, valid_in1;
  logic [BW-1:0] data_in0, data_in1, data_out;
  logic          out_ready, pop_D0, pop_D1, dest_out, valid_out;
  logic          req, req_idx, clr, count_valid, idle, proto_err;
  logic [CW-1:0] count_out;

  typedef struct packed {
    logic          dest;
    logic [BW-1:0] data;
  } word_t;

  word_t         sb[$];
  int            pop_log[$];
  logic          fixed_en, spur_req;
  logic [BW-1:0] fixed_data;
  int            total = 0;
  int            bad = 0;

  pcie_drain #(.BITNUMBER(BW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .can_pop0(can_pop0), .can_pop1(can_pop1),
    .valid_in0(valid_in0), .valid_in1(valid_in1),
    .data_in0(data_in0), .data_in1(data_in1),
    .out_ready(out_ready), .pop_D0(pop_D0), .pop_D1(pop_D1),
    .data_out(data_out), .dest_out(dest_out), .valid_out(valid_out),
    .req(req), .req_idx(req_idx), .clr(clr),
    .count_out(count_out), .count_valid(count_valid),
    .idle(idle), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    enable = 0; can_pop0 = 0; can_pop1 = 0; out_ready = 0;
    req = 0; req_idx = 0; clr = 0; spur_req = 0; fixed_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    reset = 0;
    zero_inputs();
    repeat (2) @(negedge clk);
    reset = 1;
    pop_log.delete();
  endtask

  // Responder: returns data the cycle after each pop and records the expected word.
  initial begin
    logic          pend, pend_dest, spur_nx;
    logic [BW-1:0] pend_data;
    word_t         w;
    pend = 0; pend_dest = 0; spur_nx = 0; pend_data = '0;
    valid_in0 = 0; valid_in1 = 0; data_in0 = '0; data_in1 = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 0; spur_nx = 0; sb.delete();
        valid_in0 = 0; valid_in1 = 0;
      end else begin
        valid_in0 = (pend && !pend_dest) || spur_nx;
        valid_in1 = pend && pend_dest;
        data_in0  = (pend && !pend_dest) ? pend_data : BW'($urandom);
        data_in1  = (pend && pend_dest) ? pend_data : BW'($urandom);
        pend = 0; spur_nx = 0;
      end
      #2;
      if (reset) begin
        if (pop_D0 || pop_D1) begin
          chk("pop_onehot", 32'(pop_D0 & pop_D1), 0);
          chk("pop_has_data", 32'(pop_D1 ? can_pop1 : can_pop0), 1);
          pend      = 1;
          pend_dest = pop_D1;
          pend_data = fixed_en ? fixed_data : BW'($urandom);
          w.dest = pend_dest;
          w.data = pend_data;
          sb.push_back(w);
          pop_log.push_back(int'(pop_D1));
        end
        spur_nx = spur_req;
      end
    end
  end

  // Monitor: checks delivered words in pop order and count responses against a counter model.
  initial begin
    int            mc0, mc1;
    logic          exp_cv;
    logic [CW-1:0] last_co;
    word_t         w;
    mc0 = 0; mc1 = 0; exp_cv = 0; last_co = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        mc0 = 0; mc1 = 0; exp_cv = 0; last_co = '0;
      end else begin
        chk("count_valid", 32'(count_valid), 32'(exp_cv));
        chk("count_out", 32'(count_out), 32'(last_co));
        exp_cv = req;
        if (req) last_co = req_idx ? CW'(mc1) : CW'(mc0);
        if (valid_out && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h/%0d expected none at %0t", data_out, dest_out, $time);
          end else begin
            w = sb.pop_front();
            chk("data_out", 32'(data_out), 32'(w.data));
            chk("dest_out", 32'(dest_out), 32'(w.dest));
            if (!w.dest && mc0 < 255) mc0++;
            if (w.dest && mc1 < 255) mc1++;
          end
        end
        if (clr) begin
          mc0 = 0;
          mc1 = 0;
        end
      end
    end
  end

  initial begin
    logic [BW-1:0] hold_d;
    logic          hold_s;
    reset = 0;
    zero_inputs();
    fixed_data = '0;

    // Reset values
    tick(); #1;
    chk("rst_idle", 32'(idle), 1);
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_dest_out", 32'(dest_out), 0);
    chk("rst_pop", 32'({pop_D0, pop_D1}), 0);
    chk("rst_count_out", 32'(count_out), 0);
    chk("rst_count_valid", 32'(count_valid), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    tick();
    reset = 1;

    // Single D0 word: pop in N, visible at N+2
    fixed_en = 1; fixed_data = 6'h2A;
    tick(); enable = 1; can_pop0 = 1; out_ready = 1;
    #1; chk("idle_no_pop", 32'(pop_D0), 0); chk("idle_flag", 32'(idle), 1);
    tick(); #1; chk("first_pop", 32'(pop_D0), 1); chk("lat_n", 32'(valid_out), 0); chk("run_idle", 32'(idle), 0);
    tick(); can_pop0 = 0; #1; chk("lat_n1", 32'(valid_out), 0);
    tick(); #1;
    chk("lat_n2_valid", 32'(valid_out), 1);
    chk("lat_n2_data", 32'(data_out), 32'h2A);
    chk("lat_n2_dest", 32'(dest_out), 0);
    tick(); fixed_en = 0;
    repeat (3) tick();

    // Alternation with both sources ready
    do_reset();
    tick(); enable = 1; can_pop0 = 1; can_pop1 = 1; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      if (i >= 2) chk("stream_valid", 32'(valid_out), 1);
    end
    tick(); can_pop0 = 0; can_pop1 = 0;
    chk("alt_count", 32'(pop_log.size()), 6);
    for (int i = 0; i < pop_log.size(); i++) chk("alt_order", 32'(pop_log[i]), 32'(i % 2));
    repeat (4) tick();
    chk("alt_drained", 32'(sb.size()), 0);

    // Backpressure: exactly two pops, head word holds
    do_reset();
    tick(); enable = 1; can_pop0 = 1; can_pop1 = 1; out_ready = 0;
    repeat (3) tick();
    tick(); #1; hold_d = data_out; hold_s = dest_out; chk("bp_valid", 32'(valid_out), 1);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("bp_hold_data", 32'(data_out), 32'(hold_d));
      chk("bp_hold_dest", 32'(dest_out), 32'(hold_s));
      chk("bp_no_pop", 32'(pop_D0 | pop_D1), 0);
    end
    chk("bp_pops", 32'(pop_log.size()), 2);
    tick(); out_ready = 1;
    repeat (3) tick();
    tick(); can_pop0 = 0; can_pop1 = 0;
    repeat (6) tick();
    chk("bp_drained", 32'(sb.size()), 0);

    // Counter read, clear with same-cycle read
    do_reset();
    tick(); enable = 1; can_pop1 = 1; out_ready = 1;
    repeat (3) tick();
    tick(); can_pop1 = 0;
    repeat (3) tick();
    tick(); req = 1; req_idx = 1;
    tick(); clr = 1; #1; chk("cnt_read", 32'(count_out), 3); chk("cnt_read_v", 32'(count_valid), 1);
    tick(); clr = 0; #1; chk("cnt_preclr", 32'(count_out), 3);
    tick(); req = 0; #1; chk("cnt_cleared", 32'(count_out), 0); chk("cnt_cleared_v", 32'(count_valid), 1);
    tick(); #1; chk("cnt_hold", 32'(count_out), 0); chk("cnt_hold_v", 32'(count_valid), 0);

    // Enable drop after a pop: drain, deliver, go idle; stray valid sets proto_err
    do_reset();
    tick(); enable = 1; can_pop0 = 1; out_ready = 1;
    tick(); #1; chk("drain_pop", 32'(pop_D0), 1);
    tick(); enable = 0; can_pop0 = 0; #1; chk("drain_nopop", 32'(pop_D0), 0);
    tick(); #1; chk("drain_deliver", 32'(valid_out), 1); chk("drain_not_idle", 32'(idle), 0);
    chk("drain_no_pop2", 32'(pop_D0 | pop_D1), 0);
    tick(); #1; chk("drain_still", 32'(idle), 0);
    tick(); #1; chk("drain_idle", 32'(idle), 1); chk("no_err_yet", 32'(proto_err), 0);
    tick(); spur_req = 1;
    tick(); spur_req = 0; #1; chk("err_not_early", 32'(proto_err), 0);
    tick(); #1; chk("proto_err_set", 32'(proto_err), 1);
    repeat (3) tick();
    chk("proto_err_sticky", 32'(proto_err), 1);

    // Saturation after 300 D0 transfers, then reset with a full output FIFO
    do_reset();
    tick(); enable = 1; can_pop0 = 1; out_ready = 1;
    for (int k = 0; k < 400 && pop_log.size() < 300; k++) tick();
    can_pop0 = 0;
    chk("sat_pops", 32'(pop_log.size()), 300);
    repeat (4) tick();
    tick(); req = 1; req_idx = 0;
    tick(); req = 0; #1; chk("sat_count", 32'(count_out), 255);
    tick(); can_pop0 = 1; can_pop1 = 1; out_ready = 0;
    repeat (4) tick();
    #1; chk("full_valid", 32'(valid_out), 1);
    #2; reset = 0; zero_inputs();
    #1;
    chk("arst_pop", 32'({pop_D0, pop_D1}), 0);
    chk("arst_valid", 32'(valid_out), 0);
    chk("arst_data", 32'(data_out), 0);
    chk("arst_dest", 32'(dest_out), 0);
    chk("arst_count", 32'(count_out), 0);
    chk("arst_count_v", 32'(count_valid), 0);
    chk("arst_idle", 32'(idle), 1);
    chk("arst_err", 32'(proto_err), 0);
    repeat (2) tick();
    reset = 1;
    pop_log.delete();
    tick(); req = 1; req_idx = 0;
    tick(); req = 0; #1; chk("post_rst_cnt", 32'(count_out), 0);

    // Random traffic against the scoreboard and counter model
    repeat (1500) begin
      tick();
      enable    = ($urandom_range(0, 9) != 0);
      can_pop0  = 1'($urandom_range(0, 1));
      can_pop1  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      req       = ($urandom_range(0, 3) == 0);
      req_idx   = 1'($urandom_range(0, 1));
      clr       = ($urandom_range(0, 31) == 0);
    end
    tick(); enable = 1; can_pop0 = 0; can_pop1 = 0; out_ready = 1; req = 0; clr = 0;
    repeat (8) tick();
    #1;
    chk("rand_drained", 32'(sb.size()), 0);
    chk("rand_no_err", 32'(proto_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
